// File: rtl/lane_pause_pkg.sv
// rtl/lane_pause_pkg.sv - shared types and widths for the lane clock-pause sequencer
package lane_pause_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      GRANT = 3'd2,
      HOLD  = 3'd3,
      GAP   = 3'd4
   } state_t;

   localparam int CNT_W    = 8;
   localparam int ERR_ID_W = 3;

endpackage

// File: rtl/rr_arbiter_onehot.sv
// rtl/rr_arbiter_onehot.sv - combinational round-robin pick, first set bit at or after PTR
module rr_arbiter_onehot
   import lane_pause_pkg::*;
#(
   parameter int NUM_REQ = 3
) (
   input  logic [NUM_REQ-1:0]  REQ,
   input  logic [ERR_ID_W-1:0] PTR,
   output logic [NUM_REQ-1:0]  GNT
);

   logic [NUM_REQ-1:0] hi_mask;
   logic [NUM_REQ-1:0] req_hi;
   logic [NUM_REQ-1:0] pick;

   // Requests at or above the pointer win first; otherwise wrap to the lowest set bit.
   assign hi_mask = {NUM_REQ{1'b1}} << PTR;
   assign req_hi  = REQ & hi_mask;
   assign pick    = (|req_hi) ? req_hi : REQ;
   assign GNT     = pick & (~pick + NUM_REQ'(1));

endmodule

// File: rtl/lane_pause_sequencer.sv
// rtl/lane_pause_sequencer.sv - round-robin owner of HS_IO_CLK_PAUSE with guarded pause windows
module lane_pause_sequencer
   import lane_pause_pkg::*;
#(
   parameter int NUM_REQ        = 3,
   parameter int SETUP_CYCLES   = 4,
   parameter int HOLD_CYCLES    = 4,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic [NUM_REQ-1:0]  REQ,
   input  logic [NUM_REQ-1:0]  DONE,
   output logic [NUM_REQ-1:0]  GNT,
   output logic                HS_IO_CLK_PAUSE,
   output logic                BUSY,
   output logic                TIMEOUT_ERR,
   output logic [ERR_ID_W-1:0] ERR_ID
);

   if (NUM_REQ < 1 || NUM_REQ > 8) begin : g_bad_num_req
      $error("NUM_REQ out of range 1..8");
   end
   if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15) begin : g_bad_setup
      $error("SETUP_CYCLES out of range 1..15");
   end
   if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
      $error("HOLD_CYCLES out of range 1..15");
   end
   if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
      $error("GAP_CYCLES out of range 1..15");
   end
   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES out of range 2..255");
   end

   localparam logic [CNT_W-1:0]    SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0]    HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]    GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0]    TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [ERR_ID_W-1:0] LAST_IDX   = ERR_ID_W'(NUM_REQ - 1);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ERR_ID_W-1:0] ptr_q, ptr_d;
   logic [ERR_ID_W-1:0] w_idx_q, w_idx_d;
   logic [NUM_REQ-1:0]  w_oh_q, w_oh_d;
   logic [NUM_REQ-1:0]  arb_oh;
   logic [ERR_ID_W-1:0] arb_idx;
   logic [ERR_ID_W-1:0] err_id_d;
   logic                terr_d;
   logic                w_done;

   rr_arbiter_onehot #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .REQ (REQ),
      .PTR (ptr_q),
      .GNT (arb_oh)
   );

   always_comb begin
      arb_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_oh[i]) arb_idx = ERR_ID_W'(i);
      end
   end

   // A withdrawn request ends the grant exactly like its DONE pulse.
   assign w_done = |(DONE & w_oh_q) | ~(|(REQ & w_oh_q));

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      w_idx_d  = w_idx_q;
      w_oh_d   = w_oh_q;
      err_id_d = ERR_ID;
      terr_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (|REQ) begin
               state_d = SETUP;
               w_oh_d  = arb_oh;
               w_idx_d = arb_idx;
            end
         end
         SETUP: begin
            if (cnt_q >= SETUP_LAST) state_d = GRANT;
         end
         GRANT: begin
            if (w_done) begin
               state_d = HOLD;
            end else if (cnt_q >= TO_LAST) begin
               state_d  = HOLD;
               terr_d   = 1'b1;
               err_id_d = w_idx_q;
            end
         end
         HOLD: begin
            if (cnt_q >= HOLD_LAST) begin
               state_d = GAP;
               ptr_d   = (w_idx_q == LAST_IDX) ? '0 : w_idx_q + ERR_ID_W'(1);
            end
         end
         GAP: begin
            // The last gap cycle arbitrates directly so no idle cycle is added.
            if (cnt_q >= GAP_LAST) begin
               if (|REQ) begin
                  state_d = SETUP;
                  w_oh_d  = arb_oh;
                  w_idx_d = arb_idx;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (cnt_q == {CNT_W{1'b1}}) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         ptr_q           <= '0;
         w_idx_q         <= '0;
         w_oh_q          <= '0;
         GNT             <= '0;
         HS_IO_CLK_PAUSE <= 1'b0;
         BUSY            <= 1'b0;
         TIMEOUT_ERR     <= 1'b0;
         ERR_ID          <= '0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         ptr_q           <= ptr_d;
         w_idx_q         <= w_idx_d;
         w_oh_q          <= w_oh_d;
         GNT             <= (state_d == GRANT) ? w_oh_d : '0;
         HS_IO_CLK_PAUSE <= (state_d == SETUP) || (state_d == GRANT) || (state_d == HOLD);
         BUSY            <= (state_d != IDLE);
         TIMEOUT_ERR     <= terr_d;
         ERR_ID          <= err_id_d;
      end
   end

endmodule

// File: tb/tb_lane_pause_sequencer.sv
// tb/tb_lane_pause_sequencer.sv - directed self-checking bench for lane_pause_sequencer
module tb_lane_pause_sequencer;

   logic       clk;
   logic       rst;
   logic [2:0] req, done, gnt, err_id;
   logic       pause, busy, terr;
   logic [0:0] req1, done1, gnt1;
   logic [2:0] err_id1;
   logic       pause1, busy1, terr1;

   int         n_pass = 0;
   int         n_fail = 0;
   int         n_total = 0;
   int         n;
   int         rr_order [4] = '{0, 1, 2, 0};
   logic [2:0] exp_g;

   lane_pause_sequencer u_dut (
      .CLK             (clk),
      .RESET           (rst),
      .REQ             (req),
      .DONE            (done),
      .GNT             (gnt),
      .HS_IO_CLK_PAUSE (pause),
      .BUSY            (busy),
      .TIMEOUT_ERR     (terr),
      .ERR_ID          (err_id)
   );

   lane_pause_sequencer #(
      .NUM_REQ      (1),
      .SETUP_CYCLES (1),
      .HOLD_CYCLES  (1),
      .GAP_CYCLES   (1)
   ) u_dut_min (
      .CLK             (clk),
      .RESET           (rst),
      .REQ             (req1),
      .DONE            (done1),
      .GNT             (gnt1),
      .HS_IO_CLK_PAUSE (pause1),
      .BUSY            (busy1),
      .TIMEOUT_ERR     (terr1),
      .ERR_ID          (err_id1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int cycles);
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req = '0; done = '0; req1 = '0; done1 = '0;
      step(2);
      chk("rst_pause", pause, 0);
      chk("rst_gnt", gnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_terr", terr, 0);
      chk("rst_err_id", err_id, 0);
      chk("rst_min_all", {terr1, err_id1, gnt1, pause1, busy1}, 0);

      // single request, DONE in the 5th grant cycle: 4+5+4 pause-high cycles
      rst = 1'b0; req = 3'b001;
      step(1);  chk("t1_pause_rise", pause, 1); chk("t1_gnt_wait", gnt, 0);
      step(3);  chk("t1_gnt_not_early", gnt, 0); chk("t1_pause_setup", pause, 1);
      step(1);  chk("t1_gnt_rise", gnt, 3'b001);
      step(4);  chk("t1_gnt_k5", gnt, 3'b001); done = 3'b001;
      step(1);  done = 3'b000; req = 3'b000;
      chk("t1_gnt_drop", gnt, 0); chk("t1_pause_hold", pause, 1);
      step(3);  chk("t1_pause_last", pause, 1);
      step(1);  chk("t1_pause_drop", pause, 0); chk("t1_busy_gap", busy, 1);
      step(1);  chk("t1_pause_gap2", pause, 0);
      step(1);  chk("t1_idle", busy, 0);

      // round robin with all requests held
      do_reset();
      req = 3'b111;
      for (int g = 0; g < 4; g++) begin
         int lows, waited;
         lows = 0; waited = 0;
         while (gnt == 3'b000 && waited < 30) begin
            if (pause == 1'b0) lows++;
            step(1);
            waited++;
         end
         exp_g = 3'(1 << rr_order[g]);
         chk("rr_grant", gnt, exp_g);
         chk("rr_onehot", $countones(gnt), 1);
         if (g > 0) chk("rr_gap_low", lows, 2);
         step(1);
         done = gnt;
         step(1);
         done = 3'b000;
      end
      req = 3'b000;
      step(8);  chk("rr_idle", busy, 0);

      // timeout: no DONE ever
      do_reset();
      req = 3'b010;
      step(5);  chk("to_gnt", gnt, 3'b010); chk("to_no_err_yet", terr, 0);
      n = 0;
      while (gnt == 3'b010 && n < 100) begin
         n++;
         step(1);
      end
      chk("to_gnt_len", n, 64);
      chk("to_err_pulse", terr, 1);
      chk("to_err_id", err_id, 1);
      chk("to_pause_hold", pause, 1);
      req = 3'b000;
      step(1);  chk("to_pulse_one_cycle", terr, 0); chk("to_err_id_hold", err_id, 1);
      step(2);  chk("to_pause_hold4", pause, 1);
      step(1);  chk("to_pause_drop", pause, 0);
      step(4);  chk("to_idle", busy, 0);

      // spurious DONE on another index, then withdrawn request
      do_reset();
      req = 3'b001;
      step(5);  chk("sp_gnt", gnt, 3'b001); done = 3'b100;
      step(1);  done = 3'b000; chk("sp_gnt_held", gnt, 3'b001);
      step(1);  chk("sp_still_grant", gnt, 3'b001); req = 3'b000;
      step(1);  chk("wd_hold_entry", gnt, 0); chk("wd_pause", pause, 1); chk("wd_no_terr", terr, 0);
      step(3);  chk("wd_pause_hold", pause, 1);
      step(1);  chk("wd_pause_drop", pause, 0);
      step(2);  chk("wd_idle", busy, 0);

      // reset mid-window; pointer was left at 1 by the previous window
      req = 3'b010;
      step(5);  chk("rs_pre_gnt", gnt, 3'b010);
      #2 rst = 1'b1;
      #1;
      chk("rs_gnt_async", gnt, 0);
      chk("rs_pause_async", pause, 0);
      chk("rs_busy_async", busy, 0);
      req = 3'b000;
      step(1);  rst = 1'b0; req = 3'b011;
      step(1);  chk("rs_setup_pause", pause, 1); chk("rs_setup_gnt", gnt, 0);
      step(3);  chk("rs_gnt_not_early", gnt, 0);
      step(1);  chk("rs_ptr_zero", gnt, 3'b001); done = 3'b001;
      step(1);  done = 3'b000; req = 3'b000;
      step(10); chk("rs_idle", busy, 0);

      // minimum parameters: 3 pause-high cycles, 1 low cycle between windows
      req1 = 1'b1;
      step(1);  chk("mn_setup", pause1, 1); chk("mn_setup_gnt", gnt1, 0);
      step(1);  chk("mn_gnt", gnt1, 1); chk("mn_pause_gnt", pause1, 1); done1 = 1'b1;
      step(1);  done1 = 1'b0; chk("mn_gnt_drop", gnt1, 0); chk("mn_hold", pause1, 1);
      step(1);  chk("mn_gap_low", pause1, 0); chk("mn_gap_busy", busy1, 1);
      step(1);  chk("mn_back_to_back", pause1, 1);
      step(1);  chk("mn_gnt2", gnt1, 1); done1 = 1'b1; req1 = 1'b0;
      step(1);  done1 = 1'b0; chk("mn_hold2", pause1, 1);
      step(1);  chk("mn_drop2", pause1, 0);
      step(1);  chk("mn_idle", busy1, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
